ps2_mouse_packet: RTL and testbench

//  Downstream of the PS/2 mouse init/receiver stage. Consumes its byte stream (rx_data/rx_data_valid,

---
 rtl/ps2_mouse_packet.sv | 224 ++++++++++++++++++++++
 tb/tb_ps2_mouse_packet.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_packet.sv
// ps2_mouse_packet
//   Assembles 3-byte PS/2 mouse packets from the byte stream of the PS/2
//   init/receiver stage. Decodes buttons, 9-bit signed deltas and overflow
//   flags, and resynchronises on a bad first byte or an inter-byte timeout.
//
//   Optional feature macro: PS2_MOUSE_POS_EN
//     defined   -> a clamped screen cursor (pos_x/pos_y) is accumulated
//     undefined -> no accumulator; pos_x/pos_y are tied to 0
module ps2_mouse_packet #(
  parameter int TIMEOUT_CYC = 54000,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int POS_W       = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             pkt_valid,
  output logic             btn_left,
  output logic             btn_right,
  output logic             btn_mid,
  output logic [8:0]       dx,
  output logic [8:0]       dy,
  output logic             x_ovf,
  output logic             y_ovf,
  output logic             sync_err,
  output logic [1:0]       dbg_state,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y
);

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2
  } state_t;

  // Timer only needs to reach TIMEOUT_CYC-1: the expiry check fires there.
  localparam int            TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMER_LIM = TW'(TIMEOUT_CYC - 1);

  state_t        state_r;
  logic [TW-1:0] timer_r;
  logic [7:0]    b0_r;
  logic [7:0]    b1_r;

  logic          pkt_valid_r;
  logic          sync_err_r;
  logic          btn_left_r;
  logic          btn_right_r;
  logic          btn_mid_r;
  logic [8:0]    dx_r;
  logic [8:0]    dy_r;
  logic          x_ovf_r;
  logic          y_ovf_r;

  // Decode of the packet being completed this cycle (stored byte0/byte1 + incoming byte2).
  logic          pkt_fire_s;
  logic [8:0]    dx_new_s;
  logic [8:0]    dy_new_s;
  logic          x_ovf_new_s;
  logic          y_ovf_new_s;
  logic          timeout_s;

  // Next-packet decode and event qualifiers.
  always_comb begin
    pkt_fire_s  = enable & rx_valid & (state_r == WAIT_B2);
    dx_new_s    = {b0_r[4], b1_r};
    dy_new_s    = {b0_r[5], rx_data};
    x_ovf_new_s = b0_r[6];
    y_ovf_new_s = b0_r[7];
    timeout_s   = (timer_r >= TIMER_LIM);
  end

  // Packet framing FSM, inter-byte timer and decoded output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= WAIT_B0;
      timer_r     <= {TW{1'b0}};
      b0_r        <= 8'h00;
      b1_r        <= 8'h00;
      pkt_valid_r <= 1'b0;
      sync_err_r  <= 1'b0;
      btn_left_r  <= 1'b0;
      btn_right_r <= 1'b0;
      btn_mid_r   <= 1'b0;
      dx_r        <= 9'h000;
      dy_r        <= 9'h000;
      x_ovf_r     <= 1'b0;
      y_ovf_r     <= 1'b0;
    end else begin
      pkt_valid_r <= 1'b0;
      sync_err_r  <= 1'b0;
      if (!enable) begin
        state_r <= WAIT_B0;
        timer_r <= {TW{1'b0}};
      end else begin
        case (state_r)
          WAIT_B0: begin
            timer_r <= {TW{1'b0}};
            if (rx_valid) begin
              // Bit 3 of a genuine first byte is always 1.
              if (rx_data[3]) begin
                b0_r    <= rx_data;
                state_r <= WAIT_B1;
              end else begin
                sync_err_r <= 1'b1;
              end
            end
          end
          WAIT_B1: begin
            // A byte arriving on the expiry cycle takes precedence over the timeout.
            if (rx_valid) begin
              b1_r    <= rx_data;
              timer_r <= {TW{1'b0}};
              state_r <= WAIT_B2;
            end else if (timeout_s) begin
              timer_r    <= {TW{1'b0}};
              sync_err_r <= 1'b1;
              state_r    <= WAIT_B0;
            end else begin
              timer_r <= timer_r + TW'(1);
            end
          end
          WAIT_B2: begin
            if (rx_valid) begin
              btn_left_r  <= b0_r[0];
              btn_right_r <= b0_r[1];
              btn_mid_r   <= b0_r[2];
              dx_r        <= dx_new_s;
              dy_r        <= dy_new_s;
              x_ovf_r     <= x_ovf_new_s;
              y_ovf_r     <= y_ovf_new_s;
              pkt_valid_r <= 1'b1;
              timer_r     <= {TW{1'b0}};
              state_r     <= WAIT_B0;
            end else if (timeout_s) begin
              timer_r    <= {TW{1'b0}};
              sync_err_r <= 1'b1;
              state_r    <= WAIT_B0;
            end else begin
              timer_r <= timer_r + TW'(1);
            end
          end
          default: begin
            timer_r <= {TW{1'b0}};
            state_r <= WAIT_B0;
          end
        endcase
      end
    end
  end

`ifdef PS2_MOUSE_POS_EN
  // Two guard bits above POS_W keep the signed sum free of wrap-around.
  localparam int                     SW      = POS_W + 2;
  localparam logic signed [SW-1:0]   X_MAX_S = SW'(SCREEN_W - 1);
  localparam logic signed [SW-1:0]   Y_MAX_S = SW'(SCREEN_H - 1);
  localparam logic [POS_W-1:0]       X_RST   = POS_W'(SCREEN_W / 2);
  localparam logic [POS_W-1:0]       Y_RST   = POS_W'(SCREEN_H / 2);

  logic [POS_W-1:0]     pos_x_r;
  logic [POS_W-1:0]     pos_y_r;
  logic signed [SW-1:0] sum_x_s;
  logic signed [SW-1:0] sum_y_s;

  function automatic logic [POS_W-1:0] clamp_axis(input logic signed [SW-1:0] v,
                                                  input logic signed [SW-1:0] max_v);
    logic [POS_W-1:0] r;
    if (v < $signed({SW{1'b0}})) begin
      r = {POS_W{1'b0}};
    end else if (v > max_v) begin
      r = max_v[POS_W-1:0];
    end else begin
      r = v[POS_W-1:0];
    end
    return r;
  endfunction

  // Candidate cursor positions; Y is screen-down, PS/2 dy is up-positive.
  always_comb begin
    sum_x_s = $signed({2'b00, pos_x_r}) + $signed({{(SW-9){dx_new_s[8]}}, dx_new_s});
    sum_y_s = $signed({2'b00, pos_y_r}) - $signed({{(SW-9){dy_new_s[8]}}, dy_new_s});
  end

  // Cursor accumulator, updated on the same edge that raises pkt_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x_r <= X_RST;
      pos_y_r <= Y_RST;
    end else if (pkt_fire_s) begin
      if (!x_ovf_new_s) begin
        pos_x_r <= clamp_axis(sum_x_s, X_MAX_S);
      end
      if (!y_ovf_new_s) begin
        pos_y_r <= clamp_axis(sum_y_s, Y_MAX_S);
      end
    end
  end

  assign pos_x = pos_x_r;
  assign pos_y = pos_y_r;
`else
  // Screen geometry only matters when the cursor is built.
  logic unused_cfg_s;
  assign unused_cfg_s = ^{SCREEN_W[0], SCREEN_H[0], pkt_fire_s, x_ovf_new_s, y_ovf_new_s};
  assign pos_x        = {POS_W{1'b0}};
  assign pos_y        = {POS_W{1'b0}};
`endif

  assign pkt_valid = pkt_valid_r;
  assign sync_err  = sync_err_r;
  assign btn_left  = btn_left_r;
  assign btn_right = btn_right_r;
  assign btn_mid   = btn_mid_r;
  assign dx        = dx_r;
  assign dy        = dy_r;
  assign x_ovf     = x_ovf_r;
  assign y_ovf     = y_ovf_r;
  assign dbg_state = state_r;

endmodule

// File: tb/tb_ps2_mouse_packet.sv
// tb_ps2_mouse_packet
//   Directed vectors with hand-computed expectations for ps2_mouse_packet.
//   Cursor expectations apply when PS2_MOUSE_POS_EN is defined, else 0.
module tb_ps2_mouse_packet;

  localparam int T_CYC = 50;
`ifdef PS2_MOUSE_POS_EN
  localparam bit POS_ON = 1'b1;
`else
  localparam bit POS_ON = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       pkt_valid;
  logic       btn_left;
  logic       btn_right;
  logic       btn_mid;
  logic [8:0] dx;
  logic [8:0] dy;
  logic       x_ovf;
  logic       y_ovf;
  logic       sync_err;
  logic [1:0] dbg_state;
  logic [9:0] pos_x;
  logic [9:0] pos_y;

  int checks_n;
  int errors_n;

  ps2_mouse_packet #(
    .TIMEOUT_CYC(T_CYC),
    .SCREEN_W   (640),
    .SCREEN_H   (480),
    .POS_W      (10)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .pkt_valid(pkt_valid),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .btn_mid  (btn_mid),
    .dx       (dx),
    .dy       (dy),
    .x_ovf    (x_ovf),
    .y_ovf    (y_ovf),
    .sync_err (sync_err),
    .dbg_state(dbg_state),
    .pos_x    (pos_x),
    .pos_y    (pos_y)
  );

  // 27 MHz-ish free-running clock.
  initial begin
    clk = 1'b0;
    forever #18 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_n++;
    if (got !== exp) begin
      errors_n++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_pos(input string tag, input int ex, input int ey);
    check_val({tag, "_pos_x"}, 32'(pos_x), POS_ON ? 32'(ex) : 32'd0);
    check_val({tag, "_pos_y"}, 32'(pos_y), POS_ON ? 32'(ey) : 32'd0);
  endtask

  // Drives one byte for exactly one rising edge; returns at the following
  // falling edge, where registered results of that byte are visible.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int  idle_n;
    bit  seen_err;
    bit  seen_pkt;

    checks_n = 0;
    errors_n = 0;
    rst_n    = 1'b0;
    enable   = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // Reset values.
    repeat (3) @(negedge clk);
    check_val("rst_pkt_valid", 32'(pkt_valid), 32'd0);
    check_val("rst_sync_err",  32'(sync_err),  32'd0);
    check_val("rst_dbg_state", 32'(dbg_state), 32'd0);
    check_val("rst_dx",        32'(dx),        32'd0);
    check_val("rst_dy",        32'(dy),        32'd0);
    check_val("rst_btns",      32'({btn_left, btn_right, btn_mid}), 32'd0);
    check_val("rst_ovf",       32'({x_ovf, y_ovf}), 32'd0);
    check_pos("rst", 320, 240);
    rst_n  = 1'b1;
    @(negedge clk);
    enable = 1'b1;

    // Basic packet: byte0 0x29 = left button, bit3, dy sign bit -> dx=+5, dy=-5.
    send_byte(8'h29);
    check_val("t1_state_b1", 32'(dbg_state), 32'd1);
    send_byte(8'h05);
    check_val("t1_state_b2", 32'(dbg_state), 32'd2);
    send_byte(8'hFB);
    check_val("t1_pkt_valid", 32'(pkt_valid), 32'd1);
    check_val("t1_sync_err",  32'(sync_err),  32'd0);
    check_val("t1_btns",      32'({btn_left, btn_right, btn_mid}), 32'b100);
    check_val("t1_dx",        32'(dx), 32'h005);
    check_val("t1_dy",        32'(dy), 32'h1FB);
    check_val("t1_state_b0",  32'(dbg_state), 32'd0);
    check_pos("t1", 325, 245);
    @(negedge clk);
    check_val("t1_pkt_drop", 32'(pkt_valid), 32'd0);
    check_val("t1_dx_hold",  32'(dx), 32'h005);

    // Bad first byte, then a clean zero-motion packet.
    send_byte(8'h00);
    check_val("t2_sync_err",  32'(sync_err),  32'd1);
    check_val("t2_state",     32'(dbg_state), 32'd0);
    check_val("t2_no_pkt",    32'(pkt_valid), 32'd0);
    @(negedge clk);
    check_val("t2_sync_drop", 32'(sync_err),  32'd0);
    send_pkt(8'h08, 8'h00, 8'h00);
    check_val("t2_pkt_valid", 32'(pkt_valid), 32'd1);
    check_val("t2_dx",        32'(dx), 32'h000);
    check_val("t2_dy",        32'(dy), 32'h000);
    check_val("t2_btn_left",  32'(btn_left), 32'd0);
    check_pos("t2", 325, 245);

    // Timeout inside a packet: sync_err after exactly T_CYC idle cycles.
    send_byte(8'h08);
    send_byte(8'h01);
    idle_n   = 0;
    seen_err = 1'b0;
    seen_pkt = 1'b0;
    for (int i = 1; i <= T_CYC + 5; i++) begin
      @(negedge clk);
      if (pkt_valid) seen_pkt = 1'b1;
      if (sync_err && !seen_err) begin
        seen_err = 1'b1;
        idle_n   = i;
        check_val("t3_state_after_to", 32'(dbg_state), 32'd0);
      end
    end
    check_val("t3_timeout_seen",  32'(seen_err), 32'd1);
    check_val("t3_timeout_cycle", 32'(idle_n),   32'(T_CYC));
    check_val("t3_no_pkt",        32'(seen_pkt), 32'd0);
    send_pkt(8'h18, 8'hFF, 8'h01);
    check_val("t3_pkt_valid", 32'(pkt_valid), 32'd1);
    check_val("t3_dx",        32'(dx), 32'h1FF);
    check_val("t3_dy",        32'(dy), 32'h001);
    check_pos("t3", 324, 244);

    // Byte arriving on the expiry cycle wins over the timeout.
    send_byte(8'h08);
    send_byte(8'h03);
    repeat (T_CYC - 2) @(negedge clk);
    check_val("t3b_no_early_to", 32'(sync_err), 32'd0);
    send_byte(8'h00);
    check_val("t3b_pkt_valid", 32'(pkt_valid), 32'd1);
    check_val("t3b_sync_err",  32'(sync_err),  32'd0);
    check_val("t3b_dx",        32'(dx), 32'h003);
    check_pos("t3b", 327, 244);

    // Saturation of X at the right edge.
    do_reset();
    send_pkt(8'h08, 8'h7F, 8'h00);
    check_pos("t4_first", 447, 240);
    for (int k = 1; k < 6; k++) send_pkt(8'h08, 8'h7F, 8'h00);
    check_val("t4_dx", 32'(dx), 32'h07F);
    check_pos("t4_sat", 639, 240);

    // X overflow flag: axis not updated.
    do_reset();
    send_pkt(8'h48, 8'h10, 8'h00);
    check_val("t5_ovf", 32'({x_ovf, y_ovf}), 32'b10);
    check_val("t5_dx",  32'(dx), 32'h010);
    check_pos("t5", 320, 240);

    // Enable dropped mid-packet: partial packet discarded.
    send_byte(8'h08);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    check_val("t6_state_en", 32'(dbg_state), 32'd0);
    check_val("t6_no_strobe", 32'({pkt_valid, sync_err}), 32'd0);
    send_pkt(8'h08, 8'h02, 8'h00);
    check_val("t6_pkt_valid", 32'(pkt_valid), 32'd1);
    check_val("t6_dx",        32'(dx), 32'h002);
    check_val("t6_x_ovf",     32'(x_ovf), 32'd0);
    check_pos("t6", 322, 240);

    // Bytes ignored while disabled, with no strobes.
    enable = 1'b0;
    send_byte(8'h00);
    check_val("t7_no_sync_err", 32'(sync_err), 32'd0);
    send_byte(8'h08);
    check_val("t7_state", 32'(dbg_state), 32'd0);
    enable = 1'b1;

    // Reset mid-packet: immediate return to reset values.
    send_byte(8'h08);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("t8_state_rst", 32'(dbg_state), 32'd0);
    check_val("t8_dx_rst",    32'(dx), 32'h000);
    check_pos("t8_rst", 320, 240);
    @(negedge clk);
    rst_n = 1'b1;
    send_pkt(8'h08, 8'h02, 8'h00);
    check_val("t8_pkt_valid", 32'(pkt_valid), 32'd1);
    check_val("t8_dx",        32'(dx), 32'h002);
    check_pos("t8", 322, 240);

    $display("Simulation finished: %0d checks, %0d errors", checks_n, errors_n);
    $finish;
  end

endmodule
